// File: rtl/vend_ctrl_param.sv
// Parametrised two-coin vending controller with vend, cancel/refund and serial
// change payout. Inputs are edge-detected; all outputs are registered.
module vend_ctrl_param #(
  parameter int unsigned CREDIT_W   = 9,
  parameter int unsigned COIN_A     = 50,
  parameter int unsigned COIN_B     = 100,
  parameter int unsigned PRICE      = 200,
  parameter int unsigned MAX_CREDIT = 300,
  parameter int unsigned UNIT       = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                vend,
  input  logic                cancel,
  output logic [1:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                reject
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    READY  = 2'd2,
    CHANGE = 2'd3
  } state_t;

  // Sums are formed one bit wider than the credit register so overflow of
  // the register itself can never mask an over-limit coin.
  localparam logic [CREDIT_W:0]   COIN_A_X = (CREDIT_W+1)'(COIN_A);
  localparam logic [CREDIT_W:0]   COIN_B_X = (CREDIT_W+1)'(COIN_B);
  localparam logic [CREDIT_W:0]   MAX_X    = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(UNIT);

  logic coin_a_reg, coin_b_reg, vend_reg, cancel_reg;
  logic coin_a_trig, coin_b_trig, vend_trig, cancel_trig;

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic                dispense_n, change_n, reject_n;
  logic [CREDIT_W:0]   sum_a, sum_b;
  logic                cancel_ok, vend_ok, any_coin;

  always_ff @(posedge clk) begin
    if (rst) begin
      coin_a_reg  <= 1'b0;
      coin_b_reg  <= 1'b0;
      vend_reg    <= 1'b0;
      cancel_reg  <= 1'b0;
      coin_a_trig <= 1'b0;
      coin_b_trig <= 1'b0;
      vend_trig   <= 1'b0;
      cancel_trig <= 1'b0;
    end else begin
      coin_a_reg  <= coin_a;
      coin_b_reg  <= coin_b;
      vend_reg    <= vend;
      cancel_reg  <= cancel;
      coin_a_trig <= coin_a & ~coin_a_reg;
      coin_b_trig <= coin_b & ~coin_b_reg;
      vend_trig   <= vend & ~vend_reg;
      cancel_trig <= cancel & ~cancel_reg;
    end
  end

  function automatic state_t settle(input logic [CREDIT_W-1:0] c);
    if (c == '0)          return IDLE;
    else if (c < PRICE_C) return ACCUM;
    else                  return READY;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      reject       <= 1'b0;
    end else begin
      state_q      <= state_n;
      credit_q     <= credit_n;
      dispense     <= dispense_n;
      change_pulse <= change_n;
      reject       <= reject_n;
    end
  end

  assign sum_a     = {1'b0, credit_q} + COIN_A_X;
  assign sum_b     = {1'b0, credit_q} + COIN_B_X;
  assign any_coin  = coin_a_trig | coin_b_trig;
  // Ignored requests (cancel in IDLE, vend before READY) do not outrank coins.
  assign cancel_ok = cancel_trig && (state_q == ACCUM || state_q == READY);
  assign vend_ok   = vend_trig && (state_q == READY);

  always_comb begin
    state_n    = state_q;
    credit_n   = credit_q;
    dispense_n = 1'b0;
    change_n   = 1'b0;
    reject_n   = 1'b0;

    if (state_q == CHANGE) begin
      change_n = 1'b1;
      reject_n = any_coin;
      if (credit_q <= UNIT_C) begin
        credit_n = '0;
        state_n  = IDLE;
      end else begin
        credit_n = credit_q - UNIT_C;
      end
    end else if (cancel_ok) begin
      state_n  = CHANGE;
      reject_n = any_coin;
    end else if (vend_ok) begin
      dispense_n = 1'b1;
      reject_n   = any_coin;
      credit_n   = credit_q - PRICE_C;
      state_n    = (credit_q == PRICE_C) ? IDLE : CHANGE;
    end else if (coin_b_trig) begin
      reject_n = coin_a_trig;
      if (sum_b <= MAX_X) begin
        credit_n = sum_b[CREDIT_W-1:0];
        state_n  = settle(sum_b[CREDIT_W-1:0]);
      end else begin
        reject_n = 1'b1;
      end
    end else if (coin_a_trig) begin
      if (sum_a <= MAX_X) begin
        credit_n = sum_a[CREDIT_W-1:0];
        state_n  = settle(sum_a[CREDIT_W-1:0]);
      end else begin
        reject_n = 1'b1;
      end
    end
  end

  assign state  = state_q;
  assign credit = credit_q;

endmodule
